// File: rtl/uart_pkg.sv
// uart_pkg: shared parity codes, receiver state encoding and baud divider helper
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
  // Rounded clock divider that produces OVS ticks per bit.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with count; drops writes when full unless a pop frees a slot
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic full, pop, push;
  // A pop always frees the head slot, so a simultaneous push into a full FIFO is accepted.
  always_comb begin
    full = count_q == (AW+1)'(DEPTH);
    pop = rd_ready && count_q != '0;
    push = wr_en && (!full || pop);
    drop = wr_en && !push;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
  end
  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rd_valid = count_q != '0;
  assign rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with per-word error flags feeding a FWFT FIFO
module uart_rx_fifo import uart_pkg::*; #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD = 9600,
  parameter int OVS = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic [1:0]                    rd_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          busy
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int DW = $clog2(DIV + 1);
  localparam int CW = $clog2(OVS + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  rx_state_t state_q, state_d;
  logic rx_meta_q, rx_meta_d, rxs_q, rxs_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic pe_q, pe_d, fe_q, fe_d, armed_q, armed_d, push_q, push_d, overflow_q, overflow_d;
  logic tick, mid, drop;
  logic [DATA_BITS+1:0] head;
  // Synchroniser, tick divider and receive FSM next-state logic.
  always_comb begin
    rx_meta_d = rx;
    rxs_d = rx_meta_q;
    tick = div_q == DW'(DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
    mid = tick && cnt_q == CW'(OVS - 1);
    state_d = state_q;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
    bit_d = bit_q;
    data_d = data_q;
    pe_d = pe_q;
    fe_d = fe_q;
    armed_d = armed_q;
    push_d = 1'b0;
    overflow_d = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
    case (state_q)
      S_IDLE: begin
        if (tick && rxs_q) armed_d = 1'b1;
        if (tick && !rxs_q && armed_q) begin
          state_d = S_START;
          cnt_d = '0;
          pe_d = 1'b0;
          fe_d = 1'b0;
        end
      end
      S_START: if (tick && cnt_q == CW'(OVS / 2 - 1)) begin
        state_d = rxs_q ? S_IDLE : S_DATA;
        cnt_d = '0;
        bit_d = '0;
      end
      S_DATA: if (mid) begin
        data_d = {rxs_q, data_q[DATA_BITS-1:1]};
        cnt_d = '0;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = PARITY != PARITY_NONE ? S_PARITY : S_STOP;
          bit_d = '0;
        end
      end
      S_PARITY: if (mid) begin
        pe_d = (^data_q ^ rxs_q) != (PARITY == PARITY_ODD);
        cnt_d = '0;
        state_d = S_STOP;
      end
      S_STOP: if (mid) begin
        cnt_d = '0;
        bit_d = bit_q + 1'b1;
        if (!rxs_q) begin
          fe_d = 1'b1;
          armed_d = 1'b0;
        end
        if (bit_q == BW'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          push_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Receiver state registers; synchroniser resets to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rx_meta_q <= 1'b1;
      rxs_q <= 1'b1;
      div_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      armed_q <= 1'b1;
      push_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_meta_q <= rx_meta_d;
      rxs_q <= rxs_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      data_q <= data_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      armed_q <= armed_d;
      push_q <= push_d;
      overflow_q <= overflow_d;
    end
  end
  sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .wr_en(push_q),
    .wr_data({pe_q, fe_q, data_q}),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(head),
    .count(fifo_count),
    .drop(drop)
  );
  assign rd_data = head[DATA_BITS-1:0];
  assign rd_err = head[DATA_BITS+1:DATA_BITS];
  assign overflow = overflow_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed tests of the UART receiver FIFO (8N1 instance and 8E1 instance)
module tb_uart_rx_fifo;
  localparam int BIT = 128;
  logic clk = 1'b0, reset = 1'b0;
  logic rx = 1'b1, rd_ready = 1'b0, clr_overflow = 1'b0;
  logic rx_p = 1'b1, rd_ready_p = 1'b0, clr_overflow_p = 1'b0;
  logic rd_valid, overflow, busy, rd_valid_p, overflow_p, busy_p;
  logic [7:0] rd_data, rd_data_p;
  logic [1:0] rd_err, rd_err_p;
  logic [4:0] fifo_count, fifo_count_p;
  int total = 0, bad = 0;

  uart_rx_fifo #(.CLK_HZ(1_200_000), .BAUD(9600), .OVS(16), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .fifo_count(fifo_count), .overflow(overflow),
    .clr_overflow(clr_overflow), .busy(busy));

  uart_rx_fifo #(.CLK_HZ(1_200_000), .BAUD(9600), .OVS(16), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) dut_p (
    .clk(clk), .reset(reset), .rx(rx_p), .rd_ready(rd_ready_p), .rd_valid(rd_valid_p),
    .rd_data(rd_data_p), .rd_err(rd_err_p), .fifo_count(fifo_count_p), .overflow(overflow_p),
    .clr_overflow(clr_overflow_p), .busy(busy_p));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_a(input logic v);
    rx = v;
    idle(BIT);
  endtask

  task automatic send_a(input logic [7:0] d, input logic stop);
    bit_a(1'b0);
    for (int i = 0; i < 8; i++) bit_a(d[i]);
    bit_a(stop);
    rx = 1'b1;
  endtask

  task automatic send_p(input logic [7:0] d, input logic par);
    rx_p = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_p = d[i];
      idle(BIT);
    end
    rx_p = par;
    idle(BIT);
    rx_p = 1'b1;
    idle(BIT);
  endtask

  task automatic pop_a();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic pop_p();
    rd_ready_p = 1'b1;
    @(negedge clk);
    rd_ready_p = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    reset = 1'b1;
    idle(3);
    total++;
    if ({rd_valid, rd_data, rd_err, fifo_count, overflow, busy} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h e=%b c=%0d o=%b b=%b want all 0",
               rd_valid, rd_data, rd_err, fifo_count, overflow, busy);
    end
    total++;
    if ({rd_valid_p, fifo_count_p, busy_p} !== 7'h0) begin
      bad++;
      $display("FAIL reset_parity_dut got v=%b c=%0d b=%b want 0", rd_valid_p, fifo_count_p, busy_p);
    end
    reset = 1'b0;
    idle(BIT);
  endtask

  task automatic test_basic();
    send_a(8'h41, 1'b1);
    idle(4);
    total++;
    if ({rd_valid, rd_data, rd_err, fifo_count} !== {1'b1, 8'h41, 2'b00, 5'd1}) begin
      bad++;
      $display("FAIL basic_word got v=%b d=%h e=%b c=%0d want v=1 d=41 e=00 c=1",
               rd_valid, rd_data, rd_err, fifo_count);
    end
    pop_a();
    total++;
    if ({rd_valid, fifo_count} !== 6'd0) begin
      bad++;
      $display("FAIL basic_pop got v=%b c=%0d want v=0 c=0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    idle(15);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy_start got %b want 1", busy);
    end
    idle(5);
    rx = 1'b1;
    idle(BIT);
    total++;
    if ({busy, rd_valid, fifo_count} !== 7'd0) begin
      bad++;
      $display("FAIL glitch_reject got busy=%b v=%b c=%0d want 0 0 0", busy, rd_valid, fifo_count);
    end
  endtask

  task automatic test_pop_empty();
    rd_ready = 1'b1;
    idle(3);
    rd_ready = 1'b0;
    total++;
    if ({rd_valid, fifo_count} !== 6'd0) begin
      bad++;
      $display("FAIL pop_empty got v=%b c=%0d want v=0 c=0", rd_valid, fifo_count);
    end
  endtask

  task automatic test_parity();
    send_p(8'h42, 1'b1);
    idle(4);
    total++;
    if ({rd_data_p, rd_err_p} !== {8'h42, 2'b10}) begin
      bad++;
      $display("FAIL parity_bad got d=%h e=%b want d=42 e=10", rd_data_p, rd_err_p);
    end
    pop_p();
    send_p(8'h42, 1'b0);
    idle(4);
    total++;
    if ({rd_data_p, rd_err_p, fifo_count_p} !== {8'h42, 2'b00, 5'd1}) begin
      bad++;
      $display("FAIL parity_good got d=%h e=%b c=%0d want d=42 e=00 c=1", rd_data_p, rd_err_p, fifo_count_p);
    end
    pop_p();
    send_p(8'h43, 1'b0);
    idle(4);
    total++;
    if ({rd_data_p, rd_err_p} !== {8'h43, 2'b10}) begin
      bad++;
      $display("FAIL parity_odd_count got d=%h e=%b want d=43 e=10", rd_data_p, rd_err_p);
    end
    pop_p();
  endtask

  task automatic test_framing();
    send_a(8'h55, 1'b0);
    idle(BIT);
    total++;
    if ({rd_data, rd_err, fifo_count} !== {8'h55, 2'b01, 5'd1}) begin
      bad++;
      $display("FAIL framing_word got d=%h e=%b c=%0d want d=55 e=01 c=1", rd_data, rd_err, fifo_count);
    end
    pop_a();
    rx = 1'b0;
    idle(30 * BIT);
    rx = 1'b1;
    idle(2 * BIT);
    total++;
    if ({rd_data, rd_err, fifo_count} !== {8'h00, 2'b01, 5'd1}) begin
      bad++;
      $display("FAIL break_single got d=%h e=%b c=%0d want d=00 e=01 c=1", rd_data, rd_err, fifo_count);
    end
    pop_a();
    send_a(8'h33, 1'b1);
    idle(4);
    total++;
    if ({rd_data, rd_err, fifo_count} !== {8'h33, 2'b00, 5'd1}) begin
      bad++;
      $display("FAIL after_break got d=%h e=%b c=%0d want d=33 e=00 c=1", rd_data, rd_err, fifo_count);
    end
    pop_a();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) send_a(8'(i), 1'b1);
    idle(4);
    total++;
    if ({fifo_count, overflow} !== {5'd16, 1'b1}) begin
      bad++;
      $display("FAIL overflow_full got c=%0d o=%b want c=16 o=1", fifo_count, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd_data !== 8'(i)) begin
        bad++;
        $display("FAIL overflow_order[%0d] got %h want %h", i, rd_data, 8'(i));
      end
      pop_a();
    end
    total++;
    if ({fifo_count, overflow} !== {5'd0, 1'b1}) begin
      bad++;
      $display("FAIL overflow_sticky got c=%0d o=%b want c=0 o=1", fifo_count, overflow);
    end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clear got %b want 0", overflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'hA5;
    send_a(8'h11, 1'b1);
    idle(4);
    total++;
    if (fifo_count !== 5'd1) begin
      bad++;
      $display("FAIL reset_mid_prefill got c=%0d want 1", fifo_count);
    end
    bit_a(1'b0);
    for (int i = 0; i < 3; i++) bit_a(d[i]);
    rx = d[3];
    idle(BIT / 2);
    reset = 1'b1;
    #1;
    total++;
    if ({rd_valid, rd_data, rd_err, fifo_count, overflow, busy} !== 18'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs got v=%b d=%h e=%b c=%0d o=%b b=%b want all 0",
               rd_valid, rd_data, rd_err, fifo_count, overflow, busy);
    end
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2 * BIT);
    send_a(8'hA5, 1'b1);
    idle(4);
    total++;
    if ({rd_data, rd_err, fifo_count} !== {8'hA5, 2'b00, 5'd1}) begin
      bad++;
      $display("FAIL reset_mid_next got d=%h e=%b c=%0d want d=a5 e=00 c=1", rd_data, rd_err, fifo_count);
    end
    pop_a();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_pop_empty();
    test_parity();
    test_framing();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
